fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 121 ++++++++++++
 tb/tb_fetch_stage.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage -- instruction fetch stage with PC register and IF/ID latch.
//
// The PC register drives the program memory address. The memory returns
// instruction_in combinationally, and the fetch stage registers that word into
// the IF/ID latch on the next edge together with PC+4.
//
// Next-PC priority: jump_reg > jump > branch_taken > stall (hold) > PC+4.
// A redirect always updates the PC, even while stall is high.
//
// Ports
//   clk, reset          rising-edge clock; asynchronous active-high reset
//   stall               hold PC (unless redirected) and IF/ID contents
//   flush               load a bubble into IF/ID (wins over stall)
//   branch_taken/target redirect to branch_target (low two bits cleared)
//   jump/jump_index     redirect to {if_id_pc_plus4[31:28], index, 2'b00}
//   jump_reg/jr_target  redirect to jr_target (low two bits cleared)
//   instruction_in      word that program memory returns for pc_out
//   pc_out              registered PC
//   if_id_*             registered instruction, PC+4 and valid flag
//   addr_err            sticky flag for a misaligned branch/jr redirect
//   fetch_count         count of IF/ID loads
//
// Optional feature: define FETCH_COUNT_EN to build the fetch counter.
// Without it, fetch_count is tied to zero and no counter register exists.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_target,
  input  logic                  jump,
  input  logic [25:0]           jump_index,
  input  logic                  jump_reg,
  input  logic [DATA_WIDTH-1:0] jr_target,
  input  logic [DATA_WIDTH-1:0] instruction_in,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] if_id_instruction,
  output logic [DATA_WIDTH-1:0] if_id_pc_plus4,
  output logic                  if_id_valid,
  output logic                  addr_err,
  output logic [31:0]           fetch_count
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] jump_target;
  logic [DATA_WIDTH-1:0] next_pc;
  logic                  misaligned;

  // The adder wraps naturally, so 0xFFFF_FFFC advances to 0.
  assign pc_plus4    = pc_out + PC_STEP;
  assign jump_target = {if_id_pc_plus4[DATA_WIDTH-1 -: 4], jump_index, 2'b00};

  always_comb begin
    next_pc    = pc_plus4;
    misaligned = 1'b0;
    if (jump_reg) begin
      next_pc    = {jr_target[DATA_WIDTH-1:2], 2'b00};
      misaligned = |jr_target[1:0];
    end else if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc    = {branch_target[DATA_WIDTH-1:2], 2'b00};
      misaligned = |branch_target[1:0];
    end else if (stall) begin
      next_pc = pc_out;
    end
  end

  // PC register and sticky alignment error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_out   <= RESET_VECTOR;
      addr_err <= 1'b0;
    end else begin
      pc_out <= next_pc;
      if (misaligned) begin
        addr_err <= 1'b1;
      end
    end
  end

  // IF/ID latch: a flush loads a bubble, a stall holds, otherwise the
  // instruction returned for the current PC is captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id_instruction <= '0;
      if_id_pc_plus4    <= '0;
      if_id_valid       <= 1'b0;
    end else if (flush) begin
      if_id_instruction <= '0;
      if_id_pc_plus4    <= '0;
      if_id_valid       <= 1'b0;
    end else if (!stall) begin
      if_id_instruction <= instruction_in;
      if_id_pc_plus4    <= pc_plus4;
      if_id_valid       <= 1'b1;
    end
  end

`ifdef FETCH_COUNT_EN
  // Counts each IF/ID load; wraps from 0xFFFF_FFFF to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
    end else if (!flush && !stall) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, branch_taken, jump, jump_reg;
  logic [31:0] branch_target, jr_target;
  logic [25:0] jump_index;
  logic [31:0] instruction_in;
  logic [31:0] pc_out, if_id_instruction, if_id_pc_plus4;
  logic        if_id_valid, addr_err;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_count;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index),
    .jump_reg(jump_reg), .jr_target(jr_target),
    .instruction_in(instruction_in), .pc_out(pc_out),
    .if_id_instruction(if_id_instruction), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid), .addr_err(addr_err), .fetch_count(fetch_count)
  );

  // Program memory model: a distinct word for every address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  assign instruction_in = mem(pc_out);

  typedef struct {
    logic        st, fl, br;
    logic [31:0] bt;
    logic        j;
    logic [25:0] ji;
    logic        jr;
    logic [31:0] jrt;
    logic [31:0] e_pc, e_instr, e_pp4;
    logic        e_valid, e_err;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic st, fl, br, input logic [31:0] bt,
                              input logic j, input logic [25:0] ji,
                              input logic jr, input logic [31:0] jrt,
                              input logic [31:0] e_pc, e_instr, e_pp4,
                              input logic e_valid, e_err);
    vec_t v;
    v.st = st; v.fl = fl; v.br = br; v.bt = bt; v.j = j; v.ji = ji;
    v.jr = jr; v.jrt = jrt; v.e_pc = e_pc; v.e_instr = e_instr;
    v.e_pp4 = e_pp4; v.e_valid = e_valid; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, e_instr, e_pp4,
                         input logic e_valid, e_err);
    chk({tag, " pc_out"}, pc_out, e_pc);
    chk({tag, " if_id_instruction"}, if_id_instruction, e_instr);
    chk({tag, " if_id_pc_plus4"}, if_id_pc_plus4, e_pp4);
    chk({tag, " if_id_valid"}, {31'd0, if_id_valid}, {31'd0, e_valid});
    chk({tag, " addr_err"}, {31'd0, addr_err}, {31'd0, e_err});
`ifdef FETCH_COUNT_EN
    chk({tag, " fetch_count"}, fetch_count, exp_count);
`else
    chk({tag, " fetch_count"}, fetch_count, 32'd0);
`endif
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; branch_taken = 0; jump = 0; jump_reg = 0;
    branch_target = '0; jr_target = '0; jump_index = '0;
  endtask

  initial begin
    // Columns: stall flush br bt j ji jr jrt | pc instr pp4 valid err
    vecs[0]  = mk(0,0,0,0,0,0,0,0, 32'h0040_0004, mem(32'h0040_0000), 32'h0040_0004, 1, 0);
    vecs[1]  = mk(0,0,0,0,0,0,0,0, 32'h0040_0008, mem(32'h0040_0004), 32'h0040_0008, 1, 0);
    vecs[2]  = mk(1,0,0,0,0,0,0,0, 32'h0040_0008, mem(32'h0040_0004), 32'h0040_0008, 1, 0);
    vecs[3]  = mk(1,0,0,0,0,0,0,0, 32'h0040_0008, mem(32'h0040_0004), 32'h0040_0008, 1, 0);
    vecs[4]  = mk(0,0,0,0,0,0,0,0, 32'h0040_000C, mem(32'h0040_0008), 32'h0040_000C, 1, 0);
    vecs[5]  = mk(0,0,0,0,0,0,0,0, 32'h0040_0010, mem(32'h0040_000C), 32'h0040_0010, 1, 0);
    // jump with flush: target from if_id_pc_plus4 0x00400010, IF/ID bubbled
    vecs[6]  = mk(0,1,0,0,1,26'h010_0040,0,0, 32'h0040_0100, 32'h0, 32'h0, 0, 0);
    vecs[7]  = mk(0,0,0,0,0,0,0,0, 32'h0040_0104, mem(32'h0040_0100), 32'h0040_0104, 1, 0);
    // all three redirects: jump_reg wins
    vecs[8]  = mk(0,0,1,32'h0040_0200,1,26'h000_0010,1,32'h0040_0100,
                  32'h0040_0100, mem(32'h0040_0104), 32'h0040_0108, 1, 0);
    // misaligned branch overriding a stall
    vecs[9]  = mk(1,0,1,32'h0040_0102,0,0,0,0, 32'h0040_0100, mem(32'h0040_0104), 32'h0040_0108, 1, 1);
    vecs[10] = mk(0,0,0,0,0,0,0,0, 32'h0040_0104, mem(32'h0040_0100), 32'h0040_0104, 1, 1);
    vecs[11] = mk(0,0,0,0,0,0,1,32'hFFFF_FFFC, 32'hFFFF_FFFC, mem(32'h0040_0104), 32'h0040_0108, 1, 1);
    vecs[12] = mk(0,0,0,0,0,0,0,0, 32'h0000_0000, mem(32'hFFFF_FFFC), 32'h0000_0000, 1, 1);
    // flush and stall together: PC held, bubble loaded
    vecs[13] = mk(1,1,0,0,0,0,0,0, 32'h0000_0000, 32'h0, 32'h0, 0, 1);
    // jump beats branch; if_id_pc_plus4 is 0 so the upper nibble is 0
    vecs[14] = mk(0,0,1,32'h0040_0200,1,26'h000_0100,0,0, 32'h0000_0400, mem(32'h0000_0000), 32'h0000_0004, 1, 1);
    vecs[15] = mk(0,0,0,0,0,0,1,32'h0040_0013, 32'h0040_0010, mem(32'h0000_0400), 32'h0000_0404, 1, 1);

    idle_inputs();
    exp_count = '0;
    reset = 1'b1;
    #3;
    chk_all("reset", 32'h0040_0000, 32'h0, 32'h0, 0, 0);
    $display("reset state: pc=%08h valid=%0b err=%0b", pc_out, if_id_valid, addr_err);
    #9 reset = 1'b0;   // t=12, between edges

    for (int i = 0; i < 16; i++) begin
      stall = vecs[i].st; flush = vecs[i].fl;
      branch_taken = vecs[i].br; branch_target = vecs[i].bt;
      jump = vecs[i].j; jump_index = vecs[i].ji;
      jump_reg = vecs[i].jr; jr_target = vecs[i].jrt;
      @(posedge clk);
      #1;
      if (!vecs[i].st && !vecs[i].fl) exp_count = exp_count + 32'd1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pp4,
              vecs[i].e_valid, vecs[i].e_err);
      $display("vec%0d: pc=%08h instr=%08h pp4=%08h valid=%0b err=%0b cnt=%0d",
               i, pc_out, if_id_instruction, if_id_pc_plus4, if_id_valid, addr_err, fetch_count);
    end

    // Reset asserted mid-stall/redirect takes effect without a clock edge.
    stall = 1; branch_taken = 1; branch_target = 32'h0040_0200;
    jump_reg = 1; jr_target = 32'h0040_0301;
    #2 reset = 1'b1;
    #1;
    exp_count = '0;
    chk_all("async_reset", 32'h0040_0000, 32'h0, 32'h0, 0, 0);
    $display("async reset: pc=%08h err=%0b", pc_out, addr_err);
    @(posedge clk);
    #1;
    chk_all("reset_hold", 32'h0040_0000, 32'h0, 32'h0, 0, 0);
    $display("reset held over edge: pc=%08h", pc_out);

    // Release and resume from the reset vector.
    reset = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    exp_count = exp_count + 32'd1;
    chk_all("resume", 32'h0040_0004, mem(32'h0040_0000), 32'h0040_0004, 1, 0);
    $display("resume: pc=%08h instr=%08h pp4=%08h", pc_out, if_id_instruction, if_id_pc_plus4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
